// File: rtl/fpu_mult_pipe_if.sv
// Operand/result handshake bundle for the parametrised floating-point multiplier.
// The producer/consumer side takes the master modport and the multiplier takes the slave modport.
interface fpu_mult_pipe_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rm;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, rm, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, rm, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fpu_mult_pipe.sv
// Multi-cycle IEEE-754 multiplier with configurable format, one operation in flight.
// Handles subnormal inputs, RNE/RTZ rounding, overflow, flush-to-zero and exception flags.
module fpu_mult_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    fpu_mult_pipe_if.slave   bus
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 1;
    localparam int PW  = 2 * SW;
    localparam int EW  = EXP_W + 2;
    localparam int LZW = $clog2(PW + 1);
    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND, DONE} state_t;
    state_t state_reg, state_next;

    logic [W-1:0]           a_reg, b_reg;
    logic                   rm_reg, sign_reg;
    logic                   nan_reg, snan_reg, inf_reg, zero_reg;
    logic [SW-1:0]          sig_a_reg, sig_b_reg, mant_reg;
    logic signed [EW-1:0]   ea_reg, eb_reg, exp_reg;
    logic [PW-1:0]          prod_reg;
    logic                   guard_reg, sticky_reg;
    logic [W-1:0]           result_reg;
    logic [3:0]             flags_reg;

    // Operand classification, one lane per operand
    logic [W-1:0]           op [2];
    logic [EXP_W-1:0]       exp_f [2];
    logic [MAN_W-1:0]       frac_f [2];
    logic                   is_nan [2], is_snan [2], is_inf [2], is_zero [2];
    logic [SW-1:0]          sig [2];
    logic signed [EW-1:0]   eff_exp [2];

    assign op[0] = a_reg;
    assign op[1] = b_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign exp_f[gi]   = op[gi][W-2 -: EXP_W];
            assign frac_f[gi]  = op[gi][MAN_W-1:0];
            assign is_nan[gi]  = (&exp_f[gi]) && (|frac_f[gi]);
            assign is_snan[gi] = is_nan[gi] && !frac_f[gi][MAN_W-1];
            assign is_inf[gi]  = (&exp_f[gi]) && !(|frac_f[gi]);
            assign is_zero[gi] = !(|exp_f[gi]) && !(|frac_f[gi]);
            assign sig[gi]     = {|exp_f[gi], frac_f[gi]};
            // Subnormals share the minimum normal exponent; the hidden bit carries the difference
            assign eff_exp[gi] = (|exp_f[gi]) ? EW'({2'b00, exp_f[gi]}) : EW'(1);
        end
    endgenerate

    logic [PW-1:0] prod_c;
    assign prod_c = PW'(sig_a_reg) * PW'(sig_b_reg);

    // Leading-zero count from the product MSB; the highest set bit wins
    logic [LZW-1:0]       lzc;
    logic signed [EW-1:0] lzc_s;
    logic [PW-1:0]        shifted;
    always_comb begin
        lzc = LZW'(PW);
        for (int i = 0; i < PW; i++) begin
            if (prod_reg[i]) lzc = LZW'(PW - 1 - i);
        end
    end
    assign lzc_s   = EW'(lzc);
    assign shifted = prod_reg << lzc;

    logic                 inc, carry, under, over;
    logic [SW:0]          mant_r;
    logic [MAN_W-1:0]     frac_r;
    logic signed [EW-1:0] exp_r;
    logic [W-1:0]         round_result;
    logic [3:0]           round_flags;

    always_comb begin
        inc    = !rm_reg && guard_reg && (sticky_reg || mant_reg[0]);
        mant_r = {1'b0, mant_reg} + (SW + 1)'(inc);
        carry  = mant_r[SW];
        frac_r = carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        exp_r  = exp_reg + EW'(carry);
        over   = !exp_r[EW-1] && (exp_r >= EXP_MAX);
        under  = exp_r[EW-1] || (exp_r == '0);

        round_result = {sign_reg, exp_r[EXP_W-1:0], frac_r};
        round_flags  = {3'b000, guard_reg | sticky_reg};
        if (nan_reg) begin
            round_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            round_flags  = {snan_reg, 3'b000};
        end else if (inf_reg && zero_reg) begin
            round_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            round_flags  = 4'b1000;
        end else if (inf_reg) begin
            round_result = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            round_flags  = 4'b0000;
        end else if (zero_reg) begin
            round_result = {sign_reg, {(W-1){1'b0}}};
            round_flags  = 4'b0000;
        end else if (over) begin
            round_result = rm_reg ? {sign_reg, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                  : {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            round_flags  = 4'b0101;
        end else if (under) begin
            round_result = {sign_reg, {(W-1){1'b0}}};
            round_flags  = 4'b0011;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid) state_next = UNPACK;
            UNPACK:  state_next = MUL;
            MUL:     state_next = NORM;
            NORM:    state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;      b_reg <= '0;      rm_reg <= 1'b0;   sign_reg <= 1'b0;
            nan_reg <= 1'b0;  snan_reg <= 1'b0; inf_reg <= 1'b0;  zero_reg <= 1'b0;
            sig_a_reg <= '0;  sig_b_reg <= '0;  ea_reg <= '0;     eb_reg <= '0;
            prod_reg <= '0;   exp_reg <= '0;    mant_reg <= '0;
            guard_reg <= 1'b0; sticky_reg <= 1'b0;
            result_reg <= '0; flags_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (bus.in_valid) begin
                    a_reg  <= bus.a;
                    b_reg  <= bus.b;
                    rm_reg <= bus.rm;
                end
                UNPACK: begin
                    sign_reg  <= a_reg[W-1] ^ b_reg[W-1];
                    nan_reg   <= is_nan[0] | is_nan[1];
                    snan_reg  <= is_snan[0] | is_snan[1];
                    inf_reg   <= is_inf[0] | is_inf[1];
                    zero_reg  <= is_zero[0] | is_zero[1];
                    sig_a_reg <= sig[0];
                    sig_b_reg <= sig[1];
                    ea_reg    <= eff_exp[0];
                    eb_reg    <= eff_exp[1];
                end
                MUL: begin
                    prod_reg <= prod_c;
                    exp_reg  <= ea_reg + eb_reg - BIAS;
                end
                NORM: begin
                    // Leading one lands in the MSB; an MSB already set is the shift-right-by-one case
                    exp_reg    <= exp_reg + EW'(1) - lzc_s;
                    mant_reg   <= shifted[PW-1 -: SW];
                    guard_reg  <= shifted[PW-1-SW];
                    sticky_reg <= |shifted[PW-2-SW:0];
                end
                ROUND: begin
                    result_reg <= round_result;
                    flags_reg  <= round_flags;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.result    = result_reg;
    assign bus.flags     = flags_reg;
endmodule

// File: tb/tb_fpu_mult_pipe.sv
// Directed bench for fpu_mult_pipe: half-precision and single-precision instances,
// rounding, specials, backpressure and asynchronous reset mid-operation.
module tb_fpu_mult_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    fpu_mult_pipe_if #(.EXP_W(5), .MAN_W(10)) bus16 ();
    fpu_mult_pipe_if #(.EXP_W(8), .MAN_W(23)) bus32 ();

    fpu_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    fpu_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    function automatic logic ov(input bit w);
        return w ? bus32.out_valid : bus16.out_valid;
    endfunction
    function automatic logic ir(input bit w);
        return w ? bus32.in_ready : bus16.in_ready;
    endfunction
    function automatic logic [31:0] res(input bit w);
        return w ? bus32.result : {16'h0000, bus16.result};
    endfunction
    function automatic logic [3:0] flg(input bit w);
        return w ? bus32.flags : bus16.flags;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input bit w, input logic v, input logic [31:0] av, input logic [31:0] bv,
                         input logic rmv);
        if (w) begin
            bus32.in_valid = v; bus32.a = av; bus32.b = bv; bus32.rm = rmv;
        end else begin
            bus16.in_valid = v; bus16.a = av[15:0]; bus16.b = bv[15:0]; bus16.rm = rmv;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation with out_ready held high; out_valid expected four edges after
    // the accept edge (five edges including it), with in_ready low throughout.
    task automatic op(input string tag, input bit w, input logic [31:0] av, input logic [31:0] bv,
                      input logic rmv, input logic [31:0] er, input logic [3:0] ef);
        int n;
        bit ready_seen;
        n = 0;
        while (!ir(w) && n < 20) begin tick(); n++; end
        check({tag, "/in_ready"}, 32'(ir(w)), 32'd1);
        drive(w, 1'b1, av, bv, rmv);
        tick();
        drive(w, 1'b0, 32'h0, 32'h0, 1'b0);
        n = 0;
        ready_seen = 1'b0;
        while (!ov(w) && n < 20) begin
            ready_seen = ready_seen | ir(w);
            tick();
            n++;
        end
        check({tag, "/latency"}, 32'(n), 32'd4);
        check({tag, "/busy"}, 32'(ready_seen), 32'd0);
        check({tag, "/result"}, res(w), er);
        check({tag, "/flags"}, 32'(flg(w)), 32'(ef));
        $display("op %s a=0x%0h b=0x%0h rm=%0d -> result=0x%0h flags=%b", tag, av, bv, rmv, res(w), flg(w));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        rst_n = 1'b0;
        bus16.out_ready = 1'b1;
        bus32.out_ready = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        check("reset/in_ready", 32'(bus16.in_ready), 32'd1);
        check("reset/out_valid", 32'(bus16.out_valid), 32'd0);
        check("reset/result", 32'(bus16.result), 32'd0);
        check("reset/flags", 32'(bus16.flags), 32'd0);
        rst_n = 1'b1;
        tick();

        op("mul_1p5",  0, 32'h3E00, 32'h3E00, 1'b0, 32'h4080, 4'b0000);
        op("tie_rne",  0, 32'h3C01, 32'h3E00, 1'b0, 32'h3E02, 4'b0001);
        op("tie_rtz",  0, 32'h3C01, 32'h3E00, 1'b1, 32'h3E01, 4'b0001);
        op("ovf_rne",  0, 32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 4'b0101);
        op("ovf_rtz",  0, 32'h7BFF, 32'h7BFF, 1'b1, 32'h7BFF, 4'b0101);
        op("sub_in",   0, 32'h0001, 32'h6C00, 1'b0, 32'h0C00, 4'b0000);
        op("ftz",      0, 32'h0400, 32'hB800, 1'b0, 32'h8000, 4'b0011);
        op("inf_zero", 0, 32'h7C00, 32'h0000, 1'b0, 32'h7E00, 4'b1000);
        op("snan",     0, 32'h7D00, 32'h3C00, 1'b0, 32'h7E00, 4'b1000);
        op("qnan",     0, 32'h7E00, 32'h3C00, 1'b0, 32'h7E00, 4'b0000);
        op("neg_inf",  0, 32'hFC00, 32'h3C00, 1'b0, 32'hFC00, 4'b0000);
        op("neg_zero", 0, 32'h8000, 32'h3C00, 1'b0, 32'h8000, 4'b0000);

        // Backpressure: result held while inputs churn
        bus16.out_ready = 1'b0;
        drive(0, 1'b1, 32'h3E00, 32'h3E00, 1'b0);
        tick();
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        n = 0;
        while (!bus16.out_valid && n < 20) begin tick(); n++; end
        check("bp/out_valid", 32'(bus16.out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive(0, i[0], $urandom, $urandom, i[1]);
            tick();
            check("bp/result", 32'(bus16.result), 32'h4080);
            check("bp/flags", 32'(bus16.flags), 32'd0);
            check("bp/in_ready", 32'(bus16.in_ready), 32'd0);
            check("bp/held_valid", 32'(bus16.out_valid), 32'd1);
        end
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        bus16.out_ready = 1'b1;
        tick();
        check("bp_rel/out_valid", 32'(bus16.out_valid), 32'd0);
        check("bp_rel/in_ready", 32'(bus16.in_ready), 32'd1);
        $display("op backpressure a=0x3e00 b=0x3e00 held 10 cycles -> result=0x%0h", bus16.result);

        // Reset arriving while the operation is in MUL
        drive(0, 1'b1, 32'h3C01, 32'h3E00, 1'b0);
        tick();
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst/in_ready", 32'(bus16.in_ready), 32'd1);
        check("rst/out_valid", 32'(bus16.out_valid), 32'd0);
        check("rst/result", 32'(bus16.result), 32'd0);
        check("rst/flags", 32'(bus16.flags), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | bus16.out_valid;
        end
        check("rst/stale", 32'(seen), 32'd0);
        $display("op reset_mid_mul a=0x3c01 b=0x3e00 -> discarded, out_valid seen=%0d", seen);
        op("post_rst", 0, 32'h3E00, 32'h3E00, 1'b0, 32'h4080, 4'b0000);

        // Single-precision instance
        op("f32_1p5",  1, 32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40100000, 4'b0000);
        op("f32_neg",  1, 32'h40000000, 32'hC0400000, 1'b0, 32'hC0C00000, 4'b0000);
        op("f32_tie",  1, 32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 4'b0001);
        op("f32_ovf",  1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F7FFFFF, 4'b0101);
        op("f32_sub",  1, 32'h00000001, 32'h4B000000, 1'b0, 32'h00800000, 4'b0000);
        op("f32_inf0", 1, 32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
